// File: rtl/perf_window_ctrl.sv
// Program-window cycle measurement: free-running cycle counter, start/stop capture
// strobes for the snapshot register, elapsed/run statistics and a paged display word.
module perf_window_ctrl #(
  parameter int unsigned RUNS_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_start_evt,
  input  logic        i_stop_evt,
  input  logic        i_disp_next,
  output logic [31:0] o_count,
  output logic        o_is_count,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overflow,
  output logic [31:0] o_elapsed,
  output logic [1:0]  o_disp_sel,
  output logic [31:0] o_disp_data
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_start_acc;
  logic                w_stop_acc;
  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_cyc_cnt;
  logic [CNT_W-1:0]    r_run_len;
  logic [CNT_W-1:0]    r_begin_q;
  logic [CNT_W-1:0]    r_end_q;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_elapsed;
  logic [RUNS_W-1:0]   r_runs;
  logic                r_is_count;
  logic                r_overflow;
  logic [1:0]          r_disp_sel;
  logic [CNT_W-1:0]    w_cyc_nxt;
  logic [CNT_W-1:0]    w_run_len_inc;
  logic [RUNS_W-1:0]   w_runs_inc;
  logic [CNT_W-1:0]    w_status;

  // Counter never holds 0: downstream reads a begin value of 0 as "unset"
  assign w_cyc_nxt     = (r_cyc_cnt == CNT_MAX) ? CNT_W'(1) : r_cyc_cnt + CNT_W'(1);
  assign w_run_len_inc = (r_run_len == CNT_MAX) ? CNT_MAX : r_run_len + CNT_W'(1);
  assign w_runs_inc    = (&r_runs) ? r_runs : r_runs + RUNS_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Event acceptance: start only outside RUN, stop only inside RUN; clear drops both
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_stop_acc  = 1'b0;
    if (i_clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start_evt) begin
            w_start_acc = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (i_stop_evt) begin
            w_stop_acc  = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc_cnt  <= CNT_W'(1);
      r_run_len  <= '0;
      r_begin_q  <= '0;
      r_end_q    <= '0;
      r_count    <= '0;
      r_elapsed  <= '0;
      r_runs     <= '0;
      r_is_count <= 1'b0;
      r_overflow <= 1'b0;
      r_disp_sel <= '0;
    end else begin
      r_cyc_cnt  <= w_cyc_nxt;
      r_is_count <= w_start_acc | w_stop_acc;
      if (i_disp_next) r_disp_sel <= r_disp_sel + 2'd1;
      if (i_clear) begin
        r_run_len  <= '0;
        r_begin_q  <= '0;
        r_end_q    <= '0;
        r_count    <= '0;
        r_elapsed  <= '0;
        r_runs     <= '0;
        r_overflow <= 1'b0;
      end else if (w_start_acc) begin
        r_begin_q  <= r_cyc_cnt;
        r_count    <= r_cyc_cnt;
        r_run_len  <= '0;
        r_overflow <= 1'b0;
      end else if (r_state == S_RUN) begin
        // Elapsed comes from run_len so it is immune to cycle-counter wrap
        r_run_len <= w_run_len_inc;
        if (w_run_len_inc == CNT_MAX) r_overflow <= 1'b1;
        if (w_stop_acc) begin
          r_end_q   <= r_cyc_cnt;
          r_count   <= r_cyc_cnt;
          r_elapsed <= w_run_len_inc;
          r_runs    <= w_runs_inc;
        end
      end
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[CNT_W-1]       = r_overflow;
    w_status[CNT_W-2 -: 2]  = r_state;
    w_status[RUNS_W-1:0]    = r_runs;
    case (r_disp_sel)
      2'd0:    o_disp_data = r_elapsed;
      2'd1:    o_disp_data = r_begin_q;
      2'd2:    o_disp_data = r_end_q;
      default: o_disp_data = w_status;
    endcase
  end

  assign o_count    = r_count;
  assign o_is_count = r_is_count;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_elapsed  = r_elapsed;
  assign o_disp_sel = r_disp_sel;

endmodule

// File: tb/tb_perf_window_ctrl.sv
// Self-checking bench for perf_window_ctrl: strobe scoreboard plus per-scenario checks.
module tb_perf_window_ctrl;

  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_DONE = 2;

  logic        clk;
  logic        rst;
  logic        i_clear, i_start_evt, i_stop_evt, i_disp_next;
  logic [31:0] o_count;
  logic        o_is_count, o_busy, o_done, o_overflow;
  logic [31:0] o_elapsed;
  logic [1:0]  o_disp_sel;
  logic [31:0] o_disp_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] m_cyc = 32'd1;
  int          m_st  = ST_IDLE;
  logic [1:0]  m_sel = 2'd0;
  int          m_t   = 0;

  perf_window_ctrl #(.RUNS_W(16)) dut (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_start_evt(i_start_evt),
    .i_stop_evt(i_stop_evt), .i_disp_next(i_disp_next), .o_count(o_count),
    .o_is_count(o_is_count), .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow),
    .o_elapsed(o_elapsed), .o_disp_sel(o_disp_sel), .o_disp_data(o_disp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; a strobe is due exactly one cycle after a scoreboarded event
  task automatic tick();
    logic        pend;
    logic        was_rst;
    logic [31:0] exp_c;
    pend    = (sb_q.size() != 0);
    was_rst = rst;
    exp_c   = pend ? sb_q.pop_front() : 32'd0;
    @(posedge clk);
    #1;
    m_t++;
    m_cyc = (was_rst || m_cyc == 32'hFFFF_FFFF) ? 32'd1 : m_cyc + 32'd1;
    checks++;
    if (pend && (o_is_count !== 1'b1 || o_count !== exp_c)) begin
      errors++;
      $display("FAIL strobe got is_count=%0b count=%h exp is_count=1 count=%h", o_is_count, o_count, exp_c);
    end else if (!pend && o_is_count !== 1'b0) begin
      errors++;
      $display("FAIL spurious_strobe got is_count=%0b count=%h exp is_count=0", o_is_count, o_count);
    end
  endtask

  task automatic pulse(input logic s, input logic p, input logic c, input logic d);
    i_start_evt = s; i_stop_evt = p; i_clear = c; i_disp_next = d;
    if (c) m_st = ST_IDLE;
    else if (s && m_st != ST_RUN) begin sb_q.push_back(m_cyc); m_st = ST_RUN; end
    else if (p && m_st == ST_RUN) begin sb_q.push_back(m_cyc); m_st = ST_DONE; end
    if (d) m_sel = m_sel + 2'd1;
    tick();
    i_start_evt = 1'b0; i_stop_evt = 1'b0; i_clear = 1'b0; i_disp_next = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_page(input logic [1:0] p);
    for (int i = 0; i < 4 && m_sel != p; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_clear = 0; i_start_evt = 0; i_stop_evt = 0; i_disp_next = 0;
    tick(); tick();
    rst = 1'b0; m_st = ST_IDLE; m_sel = 2'd0;
    checks++; if (o_count !== 32'd0 || o_is_count !== 1'b0) begin errors++; $display("FAIL reset_count got %h/%0b exp 0/0", o_count, o_is_count); end
    checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %0b%0b%0b exp 000", o_busy, o_done, o_overflow); end
    checks++; if (o_elapsed !== 32'd0 || o_disp_sel !== 2'd0 || o_disp_data !== 32'd0) begin errors++; $display("FAIL reset_results got %h/%0d/%h exp 0/0/0", o_elapsed, o_disp_sel, o_disp_data); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 20 && m_cyc != 32'd10; i++) idle(1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(24);
    checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin errors++; $display("FAIL basic_busy got busy=%0b done=%0b exp 1/0", o_busy, o_done); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    checks++; if (o_count !== 32'd35 || o_is_count !== 1'b0) begin errors++; $display("FAIL basic_count_held got %0d/%0b exp 35/0", o_count, o_is_count); end
    checks++; if (o_elapsed !== 32'd25) begin errors++; $display("FAIL basic_elapsed got %0d exp 25", o_elapsed); end
    checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL basic_done got done=%0b busy=%0b exp 1/0", o_done, o_busy); end
  endtask

  task automatic test_display();
    logic [31:0] exp_pg[5];
    exp_pg[0] = 32'd25; exp_pg[1] = 32'd10; exp_pg[2] = 32'd35;
    exp_pg[3] = 32'h4000_0001; exp_pg[4] = 32'd25;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_disp_data !== exp_pg[i] || o_disp_sel !== m_sel) begin
        errors++; $display("FAIL display_page%0d got sel=%0d data=%h exp sel=%0d data=%h", i, o_disp_sel, o_disp_data, m_sel, exp_pg[i]);
      end
      if (i < 4) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_same_cycle();
    int          t0;
    logic [31:0] b;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (o_done !== 1'b0 || o_elapsed !== 32'd0) begin errors++; $display("FAIL clear_idle got done=%0b elapsed=%h exp 0/0", o_done, o_elapsed); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    t0 = m_t; b = m_cyc;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL same_cycle_run got busy=%0b exp 1", o_busy); end
    idle(4);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    set_page(2'd1);
    checks++; if (o_disp_data !== b) begin errors++; $display("FAIL restart_begin got %h exp %h", o_disp_data, b); end
    idle(2);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (o_elapsed !== 32'(m_t - 1 - t0)) begin errors++; $display("FAIL same_cycle_elapsed got %0d exp %0d", o_elapsed, m_t - 1 - t0); end
  endtask

  task automatic test_wrap();
    force dut.r_cyc_cnt = 32'hFFFF_FFFD;
    tick();
    release dut.r_cyc_cnt;
    m_cyc = 32'hFFFF_FFFD;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (o_elapsed !== 32'd5) begin errors++; $display("FAIL wrap_elapsed got %0d exp 5", o_elapsed); end
    set_page(2'd1);
    checks++; if (o_disp_data !== 32'hFFFF_FFFD) begin errors++; $display("FAIL wrap_begin got %h exp fffffffd", o_disp_data); end
    set_page(2'd2);
    checks++; if (o_disp_data !== 32'd3) begin errors++; $display("FAIL wrap_end got %h exp 3", o_disp_data); end
    set_page(2'd0);
  endtask

  task automatic test_overflow();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    force dut.r_run_len = 32'hFFFF_FFFD;
    tick();
    release dut.r_run_len;
    idle(1);
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL overflow_early got %0b exp 0", o_overflow); end
    idle(2);
    checks++; if (o_overflow !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL overflow_set got ov=%0b busy=%0b exp 1/1", o_overflow, o_busy); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (o_elapsed !== 32'hFFFF_FFFF || o_overflow !== 1'b1) begin errors++; $display("FAIL overflow_elapsed got %h/%0b exp ffffffff/1", o_elapsed, o_overflow); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (o_overflow !== 1'b0 || o_done !== 1'b0 || o_elapsed !== 32'hFFFF_FFFF) begin errors++; $display("FAIL back_to_back got ov=%0b done=%0b el=%h exp 0/0/ffffffff", o_overflow, o_done, o_elapsed); end
  endtask

  task automatic test_clear_reset();
    idle(2);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_overflow !== 1'b0) begin errors++; $display("FAIL clear_flags got %0b%0b%0b exp 000", o_busy, o_done, o_overflow); end
    checks++; if (o_elapsed !== 32'd0 || o_count !== 32'd0) begin errors++; $display("FAIL clear_results got el=%h cnt=%h exp 0/0", o_elapsed, o_count); end
    set_page(2'd3);
    checks++; if (o_disp_data !== 32'd0) begin errors++; $display("FAIL clear_status got %h exp 0", o_disp_data); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    rst = 1'b1;
    tick();
    rst = 1'b0; m_st = ST_IDLE; m_sel = 2'd0;
    checks++; if (o_busy !== 1'b0 || o_is_count !== 1'b0 || o_count !== 32'd0) begin errors++; $display("FAIL rst_mid_run got busy=%0b isc=%0b cnt=%h exp 0/0/0", o_busy, o_is_count, o_count); end
    checks++; if (o_disp_sel !== 2'd0 || o_elapsed !== 32'd0 || o_disp_data !== 32'd0) begin errors++; $display("FAIL rst_results got sel=%0d el=%h data=%h exp 0/0/0", o_disp_sel, o_elapsed, o_disp_data); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic();
    test_display();
    test_same_cycle();
    test_wrap();
    test_overflow();
    test_clear_reset();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d pending exp 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_window_ctrl.md
Name: perf_window_ctrl

Overview:
- Sequences cycle-count measurement of a program window on the CPU board.
- Owns the free-running cycle counter and turns start/stop marker events into capture strobes for the downstream begin/end snapshot register.
- Computes the elapsed cycle count and run statistics.
- Multiplexes results onto one 32-bit word for the LED/segment display.

Parameters:
- RUNS_W, 16, width of the completed-run counter (saturating).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- clear  in  1  sync clear of results and FSM; priority below rst.
- start_evt  in  1  one-cycle marker: window begins this cycle.
- stop_evt  in  1  one-cycle marker: window ends this cycle.
- disp_next  in  1  one-cycle pulse (already debounced/edge-detected): advance display page.
- count  out  32  snapshot of the cycle counter at the last accepted event.
- is_count  out  1  one-cycle strobe: count is valid and must be captured.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- overflow  out  1  window length saturated during the last or current run.
- elapsed  out  32  cycles between the accepted start and stop events.
- disp_sel  out  2  current display page.
- disp_data  out  32  display word for the current page.

Behaviour:
- Reset (rst=1): cyc_cnt=1, count=0, is_count=0, state=IDLE, busy=0, done=0, overflow=0, elapsed=0, run_len=0, begin_q=0, end_q=0, runs=0, disp_sel=0.
- cyc_cnt (internal, 32b):
  - Increments every cycle.
  - Wraps 0xFFFF_FFFF -> 1; never holds 0, because downstream treats a begin value of 0 as "unset".
  - Unaffected by clear.
- FSM states: IDLE, RUN, DONE. busy=(state==RUN), done=(state==DONE), both registered from state.
- IDLE:
  - start_evt -> begin_q<=cyc_cnt, count<=cyc_cnt, is_count<=1 next cycle, run_len<=0, overflow<=0, go RUN.
  - stop_evt alone: ignored.
  - start_evt and stop_evt in the same cycle: start wins, stop dropped.
- RUN:
  - Each cycle, run_len<=run_len+1, saturating at 0xFFFF_FFFF; overflow<=1 when saturation is reached.
  - stop_evt -> end_q<=cyc_cnt, count<=cyc_cnt, is_count<=1 next cycle, elapsed<=sat(run_len+1), runs<=sat(runs+1), go DONE.
  - start_evt in RUN: ignored, no restart, including when it coincides with stop_evt.
- DONE:
  - Results held.
  - start_evt -> same actions as from IDLE (new run overwrites begin_q, overflow; elapsed holds the old value until the next stop); done drops next cycle.
  - stop_evt ignored.
- is_count is high for exactly one cycle per accepted event; count is held between events. Latency: event at cycle t -> count and is_count valid at t+1.
- Elapsed definition: start at t0, stop at t1 -> elapsed = t1-t0, independent of cyc_cnt wrap (derived from run_len, not from end_q-begin_q).
- clear (rst=0):
  - state<=IDLE; elapsed, begin_q, end_q, run_len, runs, overflow, count <=0; is_count<=0.
  - disp_sel and cyc_cnt kept.
  - Events in the clear cycle are dropped.
  - A clear in RUN aborts the window with no stop strobe.
- Display:
  - disp_next -> disp_sel<=disp_sel+1, wrapping 3->0; active in every state.
  - disp_data (combinational mux): 0: elapsed; 1: begin_q; 2: end_q; 3: {overflow, state[1:0] encoded IDLE=0/RUN=1/DONE=2, zero pad, runs in low RUNS_W bits}.
- rst asserted mid-run: full reset next edge; no strobe emitted.

Test Plan:
- Release rst, pulse start_evt at cyc_cnt=10, stop_evt 25 cycles later -> is_count high at t0+1 with count=10 and at t1+1 with count=35; elapsed=25; done=1; runs=1.
- Pulse start_evt and stop_evt together in IDLE -> RUN entered, one strobe only; later a stop gives the correct elapsed. Pulse start_evt in RUN -> no strobe, begin_q unchanged.
- Force cyc_cnt to 0xFFFF_FFFD, start, stop 5 cycles later -> begin=0xFFFF_FFFD, end=3 (0 skipped), elapsed=5.
- Force run_len near 0xFFFF_FFFF during RUN, keep running -> overflow=1, elapsed=0xFFFF_FFFF after stop; next start clears overflow.
- Assert clear mid-RUN -> IDLE, no strobe, all results 0, cyc_cnt continues; assert rst mid-RUN -> all outputs at reset values next edge.
- Complete a run, pulse disp_next four times -> disp_data steps elapsed, begin_q, end_q, status (runs=1, state=DONE), then back to elapsed.
